// File: rtl/counter_three_monitor.sv
// Receive-side checker for a 3-bit up/down counter bus: direction recovery, lock, and error/wrap/reversal flags.
// Latency: all outputs registered; the sample taken at an edge is reflected right after that edge.
// Backpressure: none; data is only sampled when en is high, otherwise all state holds and pulses drop.
module counter_three_monitor #(
  parameter int LOCK_N = 2,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        data,
  input  logic              en,
  output logic              ud,
  output logic              locked,
  output logic              err,
  output logic              wrap,
  output logic              dir_chg,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [7:0]        err_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACQ    = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  localparam logic [2:0]        LOCK_V   = 3'(LOCK_N);
  localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);

  logic [1:0]        state, state_n;
  logic [2:0]        prev, prev_n;
  logic [2:0]        run, run_n;
  logic              cand, cand_n;
  logic              ud_n;
  logic              err_n, wrap_n, dir_chg_n;
  logic [WRAP_W-1:0] wrap_cnt_n;
  logic [7:0]        err_cnt_n;

  logic [2:0] step;
  logic       step_up;
  logic       step_dn;
  logic       step_legal;
  logic       step_wrap;

  // Classify the step between the previous sample and the current one.
  always_comb begin
    step       = data - prev;
    step_up    = (step == 3'd1);
    step_dn    = (step == 3'd7);
    step_legal = step_up | step_dn;
    step_wrap  = ((prev == 3'd7) && (data == 3'd0)) || ((prev == 3'd0) && (data == 3'd7));
  end

  // Next-state logic: acquisition run tracking, lock/unlock decisions and pulse generation.
  always_comb begin
    state_n    = state;
    prev_n     = prev;
    run_n      = run;
    cand_n     = cand;
    ud_n       = ud;
    err_n      = 1'b0;
    wrap_n     = 1'b0;
    dir_chg_n  = 1'b0;
    wrap_cnt_n = wrap_cnt;
    err_cnt_n  = err_cnt;

    if (en) begin
      // prev always tracks the latest qualified sample, whatever the state.
      prev_n = data;
      case (state)
        S_IDLE: begin
          run_n   = 3'd0;
          state_n = S_ACQ;
        end

        S_ACQ: begin
          if (!step_legal) begin
            run_n = 3'd0;
          end else if ((run == 3'd0) || (step_up == cand)) begin
            cand_n = step_up;
            run_n  = run + 3'd1;
          end else begin
            // Reversal during acquisition restarts the run in the new direction.
            cand_n = step_up;
            run_n  = 3'd1;
          end
          if (step_legal && (run_n == LOCK_V)) begin
            state_n = S_LOCKED;
            ud_n    = cand_n;
          end
        end

        S_LOCKED: begin
          if (!step_legal) begin
            err_n   = 1'b1;
            state_n = S_ACQ;
            run_n   = 3'd0;
            if (err_cnt != 8'hFF) begin
              err_cnt_n = err_cnt + 8'd1;
            end
          end else begin
            if (step_up != ud) begin
              dir_chg_n = 1'b1;
              ud_n      = step_up;
            end
            // Wrap is judged independently of the reversal, so both may pulse together.
            if (step_wrap) begin
              wrap_n     = 1'b1;
              wrap_cnt_n = wrap_cnt + WRAP_ONE;
            end
          end
        end

        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      prev     <= 3'd0;
      run      <= 3'd0;
      cand     <= 1'b1;
      ud       <= 1'b1;
      err      <= 1'b0;
      wrap     <= 1'b0;
      dir_chg  <= 1'b0;
      wrap_cnt <= '0;
      err_cnt  <= 8'd0;
    end else begin
      state    <= state_n;
      prev     <= prev_n;
      run      <= run_n;
      cand     <= cand_n;
      ud       <= ud_n;
      err      <= err_n;
      wrap     <= wrap_n;
      dir_chg  <= dir_chg_n;
      wrap_cnt <= wrap_cnt_n;
      err_cnt  <= err_cnt_n;
    end
  end

  // Lock indication is a straight decode of the registered state.
  always_comb begin
    locked = (state == S_LOCKED);
  end

endmodule

// File: tb/tb_counter_three_monitor.sv
// Bench for counter_three_monitor: directed scenarios plus randomized traffic.
// Outputs are compared each cycle against a queue-based behavioural model.
// Literal expectations pin the model on the hand-worked scenarios.
module tb_counter_three_monitor;

  localparam int LOCK_N = 2;
  localparam int WRAP_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        data;
  logic              en;
  logic              ud;
  logic              locked;
  logic              err;
  logic              wrap;
  logic              dir_chg;
  logic [WRAP_W-1:0] wrap_cnt;
  logic [7:0]        err_cnt;

  always #5 clk = ~clk;

  counter_three_monitor #(.LOCK_N(LOCK_N), .WRAP_W(WRAP_W)) dut (
    .clk(clk), .reset(reset), .data(data), .en(en),
    .ud(ud), .locked(locked), .err(err), .wrap(wrap), .dir_chg(dir_chg),
    .wrap_cnt(wrap_cnt), .err_cnt(err_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: the list of legal step directions seen since acquisition
  // restarted; lock happens when the trailing same-direction streak hits LOCK_N.
  bit m_seen, m_locked, m_ud, m_err, m_wrap, m_dchg;
  int m_prev, m_wcnt, m_ecnt;
  int hist[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_seen = 0; m_locked = 0; m_ud = 1;
    m_err = 0; m_wrap = 0; m_dchg = 0;
    m_prev = 0; m_wcnt = 0; m_ecnt = 0;
    hist.delete();
  endtask

  task automatic model_step(input bit e, input int d);
    int step;
    int dir;
    int streak;
    m_err = 0; m_wrap = 0; m_dchg = 0;
    if (e) begin
      if (!m_seen) begin
        m_seen = 1;
        hist.delete();
      end else begin
        step = (d - m_prev + 8) % 8;
        dir  = (step == 1) ? 1 : (step == 7) ? -1 : 0;
        if (!m_locked) begin
          if (dir == 0) begin
            hist.delete();
          end else begin
            hist.push_back(dir);
            streak = 0;
            for (int i = hist.size() - 1; i >= 0; i--) begin
              if (hist[i] != dir) break;
              streak++;
            end
            if (streak == LOCK_N) begin
              m_locked = 1;
              m_ud = (dir == 1);
              hist.delete();
            end
          end
        end else if (dir == 0) begin
          m_err = 1;
          m_ecnt = (m_ecnt < 255) ? m_ecnt + 1 : 255;
          m_locked = 0;
          hist.delete();
        end else begin
          if ((dir == 1) != m_ud) begin
            m_dchg = 1;
            m_ud = (dir == 1);
          end
          if ((m_prev == 7 && d == 0) || (m_prev == 0 && d == 7)) begin
            m_wrap = 1;
            m_wcnt = (m_wcnt + 1) % (1 << WRAP_W);
          end
        end
      end
      m_prev = d;
    end
  endtask

  task automatic check_model();
    chk("ud", ud, m_ud);
    chk("locked", locked, m_locked);
    chk("err", err, m_err);
    chk("wrap", wrap, m_wrap);
    chk("dir_chg", dir_chg, m_dchg);
    chk("wrap_cnt", wrap_cnt, m_wcnt);
    chk("err_cnt", err_cnt, m_ecnt);
  endtask

  // Drive one sample between edges, advance the model, compare just after the edge.
  task automatic cycle(input bit e, input logic [2:0] d);
    @(negedge clk);
    en = e;
    data = d;
    model_step(e, int'(d));
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ud"}, ud, 1);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_wrap"}, wrap, 0);
    chk({tag, "_dir_chg"}, dir_chg, 0);
    chk({tag, "_wrap_cnt"}, wrap_cnt, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    en = 1'b0;
    data = 3'd0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [2:0] cur;
  bit         dir_up;
  int         r;

  initial begin
    reset = 1'b0;
    en = 1'b0;
    data = 3'd0;
    model_reset();
    #12;
    check_reset_vals("rst");
    @(negedge clk);
    reset = 1'b1;

    // Lock up: 3,4,5,6 locks after the third edge.
    cycle(1, 3'd3);
    chk("lockup_e1_locked", locked, 0);
    cycle(1, 3'd4);
    chk("lockup_e2_locked", locked, 0);
    cycle(1, 3'd5);
    chk("lockup_e3_locked", locked, 1);
    chk("lockup_ud", ud, 1);
    cycle(1, 3'd6);
    chk("lockup_err", err, 0);

    // Wrap up, then reverse and wrap down.
    cycle(1, 3'd7);
    chk("wrap_7_wrap", wrap, 0);
    cycle(1, 3'd0);
    chk("wrap_0_wrap", wrap, 1);
    chk("wrap_0_cnt", wrap_cnt, 1);
    cycle(1, 3'd1);
    chk("wrap_1_wrap", wrap, 0);
    cycle(1, 3'd0);
    chk("rev_dir_chg", dir_chg, 1);
    chk("rev_wrap", wrap, 0);
    chk("rev_ud", ud, 0);
    cycle(1, 3'd7);
    chk("wrapdn_wrap", wrap, 1);
    chk("wrapdn_cnt", wrap_cnt, 2);
    chk("wrapdn_ud", ud, 0);
    chk("wrapdn_dir_chg", dir_chg, 0);

    // Jump error and relock.
    do_reset();
    cycle(1, 3'd0);
    cycle(1, 3'd1);
    cycle(1, 3'd2);
    chk("jump_pre_locked", locked, 1);
    cycle(1, 3'd5);
    chk("jump_err", err, 1);
    chk("jump_err_cnt", err_cnt, 1);
    chk("jump_locked", locked, 0);
    cycle(1, 3'd6);
    chk("relock_6_locked", locked, 0);
    chk("relock_6_err", err, 0);
    cycle(1, 3'd7);
    chk("relock_locked", locked, 1);
    chk("relock_err_cnt", err_cnt, 1);

    // Hold is illegal.
    do_reset();
    cycle(1, 3'd2);
    cycle(1, 3'd3);
    cycle(1, 3'd4);
    cycle(1, 3'd4);
    chk("hold_err", err, 1);
    chk("hold_locked", locked, 0);

    // Gaps with en low are transparent.
    do_reset();
    cycle(1, 3'd2);
    cycle(1, 3'd3);
    cycle(1, 3'd4);
    for (int i = 0; i < 3; i++) cycle(0, 3'($urandom_range(0, 7)));
    chk("gap_hold_locked", locked, 1);
    cycle(1, 3'd5);
    chk("gap_err", err, 0);
    chk("gap_locked", locked, 1);

    // Randomized traffic: mostly legal steps, some reversals, holds and jumps.
    do_reset();
    cur = 3'($urandom_range(0, 7));
    dir_up = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        cycle(0, 3'($urandom_range(0, 7)));
      end else begin
        r = $urandom_range(0, 99);
        if (r < 5) cur = cur + 3'($urandom_range(2, 6));
        else if (r < 8) cur = cur;
        else begin
          if (r < 15) dir_up = ~dir_up;
          cur = dir_up ? cur + 3'd1 : cur - 3'd1;
        end
        cycle(1, cur);
      end
    end

    // Saturation of err_cnt, then asynchronous reset mid-pulse.
    do_reset();
    cur = 3'd0;
    cycle(1, cur);
    for (int i = 0; i < 2; i++) begin cur = cur + 3'd1; cycle(1, cur); end
    for (int i = 0; i < 300; i++) begin
      cur = cur + 3'd3;
      cycle(1, cur);
      for (int k = 0; k < 2; k++) begin cur = cur + 3'd1; cycle(1, cur); end
    end
    chk("sat_err_cnt", err_cnt, 255);
    chk("sat_locked", locked, 1);
    cur = cur + 3'd3;
    cycle(1, cur);
    chk("sat_final_err", err, 1);
    chk("sat_final_cnt", err_cnt, 255);
    reset = 1'b0;
    #1;
    check_reset_vals("async");
    model_reset();
    @(negedge clk);
    en = 1'b0;
    reset = 1'b1;
    cycle(1, 3'd5);
    chk("post_reset_locked", locked, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
